// File: rtl/counter_run_ctrl.sv
// Run/pause/clear sequencer for the 32-bit LED counter: turns button pulses into a
// prescaled count strobe, issues clears, handles terminal count and drives the LED byte select.
module counter_run_ctrl #(
    parameter int PRESC_DIV = 50_000_000,
    parameter int SCAN_DIV  = 100_000_000,
    parameter bit WRAP_EN   = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_start,
    input  logic       btn_stop,
    input  logic       btn_clear,
    input  logic       cnt_max,
    input  logic       scan_mode,
    input  logic [1:0] sw,
    output logic       cnt_en,
    output logic       cnt_clr,
    output logic [1:0] byte_sel,
    output logic [1:0] run_state,
    output logic       sat
);

    localparam int PW = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_CLEAR = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [SW-1:0] scan_q, scan_d;
    logic [1:0]    byte_sel_q, byte_sel_d;
    logic          sat_q, sat_d;

    logic sat_hit;
    logic presc_term;

    // In saturate mode the all-ones flag blocks strobes and ends the run.
    assign sat_hit    = (WRAP_EN == 1'b0) && cnt_max;
    assign presc_term = (presc_q == PRESC_LAST);

    always_comb begin
        state_d = state_q;
        sat_d   = sat_q;
        case (state_q)
            S_IDLE: begin
                if (btn_clear)      state_d = S_CLEAR;
                else if (btn_start) state_d = S_RUN;
            end
            S_RUN: begin
                if (btn_clear)     state_d = S_CLEAR;
                else if (btn_stop) state_d = S_PAUSE;
                else if (sat_hit) begin
                    state_d = S_PAUSE;
                    sat_d   = 1'b1;
                end
            end
            S_PAUSE: begin
                if (btn_clear)                state_d = S_CLEAR;
                else if (btn_start && !sat_q) state_d = S_RUN;
            end
            default: begin
                state_d = S_IDLE;
                sat_d   = 1'b0;
            end
        endcase
    end

    // Prescaler only survives RUN->RUN; any exit or fresh entry restarts it at zero.
    always_comb begin
        presc_d = '0;
        if (state_q == S_RUN && state_d == S_RUN) begin
            presc_d = presc_term ? '0 : presc_q + PW'(1);
        end
    end

    always_comb begin
        scan_d     = '0;
        byte_sel_d = sw;
        if (scan_mode) begin
            if (scan_q == SCAN_LAST) begin
                scan_d     = '0;
                byte_sel_d = byte_sel_q + 2'd1;
            end else begin
                scan_d     = scan_q + SW'(1);
                byte_sel_d = byte_sel_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            presc_q    <= '0;
            scan_q     <= '0;
            byte_sel_q <= 2'd0;
            sat_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            scan_q     <= scan_d;
            byte_sel_q <= byte_sel_d;
            sat_q      <= sat_d;
        end
    end

    assign cnt_en    = (state_q == S_RUN) && presc_term && !sat_hit;
    assign cnt_clr   = (state_q == S_CLEAR);
    assign run_state = state_q;
    assign byte_sel  = byte_sel_q;
    assign sat       = sat_q;

endmodule

// File: tb/tb_counter_run_ctrl.sv
// Bench for counter_run_ctrl: a wrapping and a saturating instance share stimulus and are
// compared against a cycle-count reference model plus directed scenario checks.
module tb_counter_run_ctrl;

    localparam int P = 4;
    localparam int S = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_start = 1'b0, btn_stop = 1'b0, btn_clear = 1'b0;
    logic       cnt_max = 1'b0, scan_mode = 1'b0;
    logic [1:0] sw = 2'd0;

    logic       en_a, clr_a, sat_a, en_b, clr_b, sat_b;
    logic [1:0] bs_a, rs_a, bs_b, rs_b;

    int total = 0;
    int bad   = 0;

    // Reference model: state numbers, RUN cycles since entry, sticky sat, scan cycles.
    int m_st[2];
    int m_run[2];
    int m_sat[2];
    int m_wrap[2] = '{1, 0};
    int m_bs;
    int m_scan;

    always #5 clk = ~clk;

    counter_run_ctrl #(.PRESC_DIV(P), .SCAN_DIV(S), .WRAP_EN(1'b1)) dut_a (
        .clk(clk), .rst(rst), .btn_start(btn_start), .btn_stop(btn_stop),
        .btn_clear(btn_clear), .cnt_max(cnt_max), .scan_mode(scan_mode), .sw(sw),
        .cnt_en(en_a), .cnt_clr(clr_a), .byte_sel(bs_a), .run_state(rs_a), .sat(sat_a)
    );

    counter_run_ctrl #(.PRESC_DIV(P), .SCAN_DIV(S), .WRAP_EN(1'b0)) dut_b (
        .clk(clk), .rst(rst), .btn_start(btn_start), .btn_stop(btn_stop),
        .btn_clear(btn_clear), .cnt_max(cnt_max), .scan_mode(scan_mode), .sw(sw),
        .cnt_en(en_b), .cnt_clr(clr_b), .byte_sel(bs_b), .run_state(rs_b), .sat(sat_b)
    );

    function automatic logic exp_en(int i);
        return (m_st[i] == 1) && (m_run[i] % P == P - 1) && !(m_wrap[i] == 0 && cnt_max);
    endfunction

    function automatic logic obs_en(int i);
        return (i == 0) ? en_a : en_b;
    endfunction
    function automatic logic obs_clr(int i);
        return (i == 0) ? clr_a : clr_b;
    endfunction
    function automatic logic obs_sat(int i);
        return (i == 0) ? sat_a : sat_b;
    endfunction
    function automatic logic [1:0] obs_rs(int i);
        return (i == 0) ? rs_a : rs_b;
    endfunction
    function automatic logic [1:0] obs_bs(int i);
        return (i == 0) ? bs_a : bs_b;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_st[i]  = 0;
            m_run[i] = 0;
            m_sat[i] = 0;
        end
        m_bs   = 0;
        m_scan = 0;
    endtask

    task automatic model_step();
        int ns;
        for (int i = 0; i < 2; i++) begin
            ns = m_st[i];
            case (m_st[i])
                0: if (btn_clear) ns = 3; else if (btn_start) ns = 1;
                1: begin
                    if (btn_clear) ns = 3;
                    else if (btn_stop) ns = 2;
                    else if (m_wrap[i] == 0 && cnt_max) begin
                        ns = 2;
                        m_sat[i] = 1;
                    end
                end
                2: if (btn_clear) ns = 3; else if (btn_start && m_sat[i] == 0) ns = 1;
                default: begin
                    ns = 0;
                    m_sat[i] = 0;
                end
            endcase
            m_run[i] = (ns == 1 && m_st[i] == 1) ? m_run[i] + 1 : 0;
            m_st[i]  = ns;
        end
        if (scan_mode) begin
            m_scan++;
            if (m_scan % S == 0) m_bs = (m_bs + 1) % 4;
        end else begin
            m_scan = 0;
            m_bs   = sw;
        end
    endtask

    // One clock: model follows the rising edge, control returns at the falling edge.
    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else model_step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        model_reset();
        tick();
        tick();
        #1;
        total++;
        if ({rs_a, en_a, clr_a, bs_a, sat_a} !== 7'd0) begin
            bad++;
            $display("FAIL reset_a: got rs=%0d en=%0b clr=%0b bs=%0d sat=%0b, want all 0",
                     rs_a, en_a, clr_a, bs_a, sat_a);
        end
        total++;
        if ({rs_b, en_b, clr_b, bs_b, sat_b} !== 7'd0) begin
            bad++;
            $display("FAIL reset_b: got rs=%0d en=%0b clr=%0b bs=%0d sat=%0b, want all 0",
                     rs_b, en_b, clr_b, bs_b, sat_b);
        end
        rst = 1'b0;
        tick();
        $display("test_reset done");
    endtask

    task automatic test_run_strobe();
        btn_start = 1'b1;
        tick();
        btn_start = 1'b0;
        #1;
        total++;
        if (rs_a !== 2'd1) begin
            bad++;
            $display("FAIL start_to_run: got run_state=%0d want 1", rs_a);
        end
        for (int k = 1; k <= 12; k++) begin
            #1;
            total++;
            if (en_a !== ((k % 4) == 0)) begin
                bad++;
                $display("FAIL run_strobe cycle %0d: got cnt_en=%0b want %0b", k, en_a, (k % 4) == 0);
            end
            tick();
        end
        $display("test_run_strobe done");
    endtask

    task automatic test_pause_resume();
        int n;
        tick();
        tick();
        btn_stop = 1'b1;
        #1;
        total++;
        if (en_a !== 1'b0) begin
            bad++;
            $display("FAIL stop_mid_presc: got cnt_en=%0b want 0", en_a);
        end
        tick();
        btn_stop = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            total++;
            if (rs_a !== 2'd2 || en_a !== 1'b0) begin
                bad++;
                $display("FAIL paused: got run_state=%0d cnt_en=%0b want 2/0", rs_a, en_a);
            end
            tick();
        end
        btn_start = 1'b1;
        tick();
        btn_start = 1'b0;
        n = 1;
        while (n <= 10) begin
            #1;
            if (en_a === 1'b1) break;
            tick();
            n++;
        end
        total++;
        if (n != 4) begin
            bad++;
            $display("FAIL resume_latency: got first strobe at RUN cycle %0d want 4", n);
        end
        btn_stop = 1'b1;
        #1;
        total++;
        if (en_a !== 1'b1) begin
            bad++;
            $display("FAIL stop_with_strobe: got cnt_en=%0b want 1", en_a);
        end
        tick();
        btn_stop = 1'b0;
        #1;
        total++;
        if (rs_a !== 2'd2) begin
            bad++;
            $display("FAIL stop_with_strobe_state: got run_state=%0d want 2", rs_a);
        end
        $display("test_pause_resume done");
    endtask

    task automatic test_simultaneous();
        btn_start = 1'b1;
        tick();
        btn_start = 1'b0;
        #1;
        total++;
        if (rs_a !== 2'd1) begin
            bad++;
            $display("FAIL resume_run: got run_state=%0d want 1", rs_a);
        end
        btn_start = 1'b1;
        btn_stop  = 1'b1;
        btn_clear = 1'b1;
        tick();
        btn_stop  = 1'b0;
        btn_clear = 1'b0;
        #1;
        total++;
        if (rs_a !== 2'd3 || clr_a !== 1'b1 || en_a !== 1'b0) begin
            bad++;
            $display("FAIL all_buttons_clear: got rs=%0d clr=%0b en=%0b want 3/1/0", rs_a, clr_a, en_a);
        end
        tick();
        btn_start = 1'b0;
        #1;
        total++;
        if (rs_a !== 2'd0 || clr_a !== 1'b0 || sat_a !== 1'b0) begin
            bad++;
            $display("FAIL clear_to_idle: got rs=%0d clr=%0b sat=%0b want 0/0/0", rs_a, clr_a, sat_a);
        end
        $display("test_simultaneous done");
    endtask

    task automatic test_terminal_count();
        btn_start = 1'b1;
        tick();
        btn_start = 1'b0;
        tick();
        tick();
        tick();
        cnt_max = 1'b1;
        #1;
        total++;
        if (en_a !== 1'b1 || en_b !== 1'b0) begin
            bad++;
            $display("FAIL cnt_max_strobe: got en_wrap=%0b en_sat=%0b want 1/0", en_a, en_b);
        end
        tick();
        cnt_max = 1'b0;
        #1;
        total++;
        if (rs_a !== 2'd1 || sat_a !== 1'b0 || rs_b !== 2'd2 || sat_b !== 1'b1) begin
            bad++;
            $display("FAIL cnt_max_state: got wrap rs=%0d sat=%0b, sat-mode rs=%0d sat=%0b want 1/0 2/1",
                     rs_a, sat_a, rs_b, sat_b);
        end
        btn_start = 1'b1;
        tick();
        btn_start = 1'b0;
        #1;
        total++;
        if (rs_b !== 2'd2 || sat_b !== 1'b1 || en_b !== 1'b0) begin
            bad++;
            $display("FAIL start_while_sat: got rs=%0d sat=%0b en=%0b want 2/1/0", rs_b, sat_b, en_b);
        end
        btn_clear = 1'b1;
        tick();
        btn_clear = 1'b0;
        #1;
        total++;
        if (rs_b !== 2'd3 || clr_b !== 1'b1) begin
            bad++;
            $display("FAIL sat_clear: got rs=%0d clr=%0b want 3/1", rs_b, clr_b);
        end
        tick();
        #1;
        total++;
        if (rs_b !== 2'd0 || sat_b !== 1'b0) begin
            bad++;
            $display("FAIL sat_recovered: got rs=%0d sat=%0b want 0/0", rs_b, sat_b);
        end
        $display("test_terminal_count done");
    endtask

    task automatic test_scan();
        scan_mode = 1'b0;
        sw = 2'd2;
        tick();
        #1;
        total++;
        if (bs_a !== 2'd2) begin
            bad++;
            $display("FAIL manual_sel: got byte_sel=%0d want 2", bs_a);
        end
        scan_mode = 1'b1;
        sw = 2'd1;
        for (int j = 0; j < 12; j++) begin
            #1;
            total++;
            if (bs_a !== 2'((2 + j / 3) % 4)) begin
                bad++;
                $display("FAIL scan_seq step %0d: got byte_sel=%0d want %0d", j, bs_a, (2 + j / 3) % 4);
            end
            tick();
        end
        scan_mode = 1'b0;
        sw = 2'd1;
        tick();
        #1;
        total++;
        if (bs_a !== 2'd1) begin
            bad++;
            $display("FAIL scan_off_sel: got byte_sel=%0d want 1", bs_a);
        end
        scan_mode = 1'b1;
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (bs_a !== 2'd0 || rs_a !== 2'd0 || en_a !== 1'b0) begin
            bad++;
            $display("FAIL async_rst: got bs=%0d rs=%0d en=%0b want 0/0/0", bs_a, rs_a, en_a);
        end
        model_reset();
        tick();
        rst = 1'b0;
        scan_mode = 1'b0;
        sw = 2'd0;
        tick();
        $display("test_scan done");
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            btn_start = ($urandom_range(0, 7) == 0);
            btn_stop  = ($urandom_range(0, 11) == 0);
            btn_clear = ($urandom_range(0, 19) == 0);
            cnt_max   = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 24) == 0) scan_mode = ~scan_mode;
            sw = 2'($urandom_range(0, 3));
            #1;
            for (int i = 0; i < 2; i++) begin
                total++;
                if (obs_en(i) !== exp_en(i) || obs_clr(i) !== (m_st[i] == 3) ||
                    obs_rs(i) !== 2'(m_st[i]) || obs_sat(i) !== (m_sat[i] != 0) ||
                    obs_bs(i) !== 2'(m_bs)) begin
                    bad++;
                    $display("FAIL random c=%0d inst=%0d: got en=%0b clr=%0b rs=%0d sat=%0b bs=%0d want en=%0b clr=%0b rs=%0d sat=%0d bs=%0d",
                             c, i, obs_en(i), obs_clr(i), obs_rs(i), obs_sat(i), obs_bs(i),
                             exp_en(i), m_st[i] == 3, m_st[i], m_sat[i], m_bs);
                end
            end
            tick();
        end
        $display("test_random done");
    endtask

    initial begin
        test_reset();
        test_run_strobe();
        test_pause_resume();
        test_simultaneous();
        test_terminal_count();
        test_scan();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
